// File: rtl/stage_clk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stage_clk_pkg
//  Description : Shared defaults and pipeline stage indices for stage_clk_ctrl
//  Revision    : 1.0
// ============================================================================
package stage_clk_pkg;

  localparam int NSTAGE_DFLT = 4;
  localparam int CNT_W_DFLT  = 4;

  localparam int STG_F   = 0;
  localparam int STG_DCD = 1;
  localparam int STG_EXE = 2;
  localparam int STG_RF  = 3;

endpackage : stage_clk_pkg
`default_nettype wire

// File: rtl/stage_clk_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : stage_clk_ctrl_if
//  Description : Stall request / stage enable bundle between core and stall ctrl
//  Revision    : 1.0
// ============================================================================
interface stage_clk_ctrl_if #(
  parameter int NSTAGE = 4,
  parameter int CNT_W  = 4
);

  logic              stallb_en;
  logic              stall_go;
  logic [CNT_W-1:0]  stall_len;
  logic              freeze;
  logic [NSTAGE-1:0] en;
  logic [NSTAGE-1:0] clk_stg;
  logic              stall_busy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output stallb_en, stall_go, stall_len, freeze,
    input  en, clk_stg, stall_busy, stall_cnt
  );

  modport slave (
    input  stallb_en, stall_go, stall_len, freeze,
    output en, clk_stg, stall_busy, stall_cnt
  );

endinterface : stage_clk_ctrl_if
`default_nettype wire

// File: rtl/stage_clk_ctrl_stall_down_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : stall_down_cnt
//  Description : Loadable down counter, saturates at zero, updates on negedge
//  Revision    : 1.0
// ============================================================================
module stall_down_cnt #(
  parameter int CNT_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic [CNT_W-1:0] len,
  input  wire logic             hold,
  output logic      [CNT_W-1:0] cnt,
  output logic                  busy
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!hold) begin
      if (load) begin
        r_cnt <= len;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign cnt  = r_cnt;
  assign busy = (r_cnt != '0);

endmodule : stall_down_cnt
`default_nettype wire

// File: rtl/stage_clk_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stage_clk_ctrl
//  Description : Per-stage enables and gated clocks with stall/freeze control
//  Revision    : 1.0
// ============================================================================
module stage_clk_ctrl
  import stage_clk_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DFLT,
  parameter int CNT_W  = CNT_W_DFLT
) (
  input  wire logic        clk_in,
  input  wire logic        rst,
  stage_clk_ctrl_if.slave  bus
);

  logic              r_frz;
  logic [NSTAGE-1:0] r_en;
  logic [NSTAGE-1:0] w_en_nxt;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_busy;
  logic              w_load;
  logic              w_cnt_done;

  assign w_load = bus.stall_go & ~w_busy & (bus.stall_len != '0);

  // Without a load, the counter reaches zero this edge iff it is now 0 or 1.
  assign w_cnt_done = ~w_busy | (w_cnt == CNT_W'(1));

  stall_down_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk  (clk_in),
    .rst  (rst),
    .load (w_load),
    .len  (bus.stall_len),
    .hold (bus.freeze),
    .cnt  (w_cnt),
    .busy (w_busy)
  );

  for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
    if (i == STG_F) begin : g_head
      assign w_en_nxt[i] = bus.stallb_en & w_cnt_done & ~w_load;
    end else begin : g_tail
      assign w_en_nxt[i] = r_en[i-1];
    end
    // Enables only move while clk_in is low, so the AND cannot glitch.
    assign bus.clk_stg[i] = r_en[i] & ~r_frz & clk_in;
  end

  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) begin
      r_frz <= 1'b0;
      r_en  <= '1;
    end else begin
      r_frz <= bus.freeze;
      if (!bus.freeze) begin
        r_en <= w_en_nxt;
      end
    end
  end

  assign bus.en         = r_en;
  assign bus.stall_busy = w_busy;
  assign bus.stall_cnt  = w_cnt;

endmodule : stage_clk_ctrl
`default_nettype wire

// File: doc/stage_clk_ctrl.md
# stage_clk_ctrl

Parametrised pipeline stall/clock controller for the RISC core. Generates one enable and one gated clock per pipeline stage (fetch, decode, execute, register-file write, and beyond), propagates a front-end stall down the pipeline one stage per cycle, and adds programmable multi-cycle stalls and a global freeze. Sits between the top-level clock input and every pipeline stage register bank.

## Interface
Parameters:
- NSTAGE, 4, number of pipeline stages (≥2); stage 0 is fetch
- CNT_W, 4, width of the multi-cycle stall counter

Ports:
- clk_in  input  1  core clock; all state updates on its falling edge
- rst  input  1  asynchronous, active-low reset
- stallb_en  input  1  level, active-low stall request for stage 0 (1 = run)
- stall_go  input  1  one-cycle pulse: start a multi-cycle stall of stall_len cycles
- stall_len  input  CNT_W  bubble count for stall_go; 0 = ignored
- freeze  input  1  level: suppress every stage clock, hold all state
- en  output  NSTAGE  registered per-stage enables
- clk_stg  output  NSTAGE  gated stage clocks
- stall_busy  output  1  multi-cycle stall in progress (cnt ≠ 0)
- stall_cnt  output  CNT_W  remaining bubbles

## Operation
- State: en[NSTAGE-1:0], cnt[CNT_W-1:0], frz_q. All updated on negedge clk_in only.
- Reset (rst=0, immediate): en = all 1, cnt = 0, frz_q = 0, stall_busy = 0, stall_cnt = 0, so clk_stg[i] = clk_in.
- frz_q <= freeze every falling edge.
- If freeze=1 at a falling edge: en and cnt hold; stall_go is dropped (not queued).
- Otherwise:
  - load = stall_go & (cnt==0) & (stall_len≠0)
  - cnt_next = load ? stall_len : (cnt≠0 ? cnt−1 : 0)
  - en[0] <= stallb_en & (cnt_next==0) & ~load
  - en[i] <= en[i−1] for i = 1..NSTAGE−1
  - cnt <= cnt_next
- stall_go while stall_busy=1 is ignored; it does not extend or restart the stall.
- stall_go together with stallb_en=0: the counter loads. en[0] stays 0 for max(stall_len, stallb_en low duration).
- clk_stg[i] = en[i] & ~frz_q & clk_in, a combinational AND. It is glitch-free because en and frz_q change only while clk_in is low.
- stall_busy = (cnt≠0); stall_cnt = cnt.

## Timing
- Inputs are sampled at the falling edge of clk_in. Outputs en, stall_busy and stall_cnt change just after that edge.
- stallb_en=0 sampled at falling edge n removes the stage-0 clock pulse in the following high phase. Stage i loses its pulse i cycles later, so one bubble travels the pipe.
- stall_go with stall_len=L at falling edge n gives exactly L consecutive missing stage-0 pulses. en[0] returns to 1 at falling edge n+L if stallb_en=1. stall_busy is high for L cycles.
- freeze sampled at edge n blocks all clk_stg pulses in the next high phase. Counting resumes on the first unfrozen edge.
- Reset asserted mid-stall or mid-freeze clears everything asynchronously. No residual bubbles remain after release.
- cnt never wraps: it decrements from stall_len to 0 and stops.

## Structure
- Shared package stage_clk_pkg holds:
  - the default NSTAGE
  - stage index constants STG_F=0, STG_DCD=1, STG_EXE=2, STG_RF=3
  - the default CNT_W
- One sub-module, stall_down_cnt: a loadable, saturating-at-zero down counter on the negedge. It has inputs load, len and hold, and outputs cnt and busy.
- The enable shift chain and clock gating live in the top module, using a generate loop over NSTAGE.

## Test plan
- Reset then free-run, NSTAGE=4: en=4'b1111 and clk_stg[i] identical to clk_in for 10 cycles; stall_busy=0.
- stallb_en low for one sampling edge: clk_stg[0] misses 1 pulse, then clk_stg[1], [2] and [3] each miss 1 pulse on successive cycles; en shows walking 0 patterns 1110→1101→1011→0111→1111.
- stall_go with stall_len=3: stall_cnt reads 3,2,1,0. clk_stg[0] misses exactly 3 pulses; each downstream stage misses 3 pulses, offset by its index. A second stall_go with len=5 while busy is ignored.
- freeze high for 4 cycles during a stall_len=3 stall: all clk_stg stay low for 4 cycles and stall_cnt holds. After release, the remaining bubbles complete.
- rst pulsed low mid-stall (stall_cnt=2, en=4'b1100): immediately en=4'b1111, stall_cnt=0, clk_stg follows clk_in.
- NSTAGE=6, CNT_W=3, stall_len=7: 7 bubbles, reaching stage 5 after 5 cycles. stall_len=0 with stall_go produces no bubble.
